// File: rtl/seq_mult_ctrl.sv
// Sequential radix-4 multiplier with valid/ready handshakes: one 2-bit multiplier digit per CALC cycle.
// Optional multiply-accumulate mode (AccClr port, running accumulator) is enabled by defining SEQ_MULT_CTRL_MAC_EN.
module seq_mult_ctrl #(
   parameter int WIDTH = 4
) (
   input  logic                 Clock,
   input  logic                 Reset_n,
   input  logic                 InValid,
   output logic                 InReady,
   input  logic [WIDTH-1:0]     Input1,
   input  logic [WIDTH-1:0]     Input2,
   output logic                 OutValid,
   input  logic                 OutReady,
   output logic [2*WIDTH-1:0]   Output,
   output logic                 Busy
`ifdef SEQ_MULT_CTRL_MAC_EN
   ,
   input  logic                 AccClr
`endif
);

   localparam int STEPS = WIDTH / 2;
   localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
   localparam int PW    = 2 * WIDTH;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(STEPS - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [WIDTH-1:0]  op1_q, op1_d;
   logic [WIDTH-1:0]  op2_q, op2_d;
   logic [PW-1:0]     prod_q, prod_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   logic [1:0]        digit;
   logic [PW-1:0]     partial;
   logic              accept;
   logic              release_result;

   assign accept         = (state_q == S_IDLE) && InValid;
   assign release_result = (state_q == S_DONE) && OutReady;

   // Current 2-bit multiplier digit, weighted by 4^cnt when added into the product.
   assign digit   = op2_q[{cnt_q, 1'b0} +: 2];
   assign partial = (PW'(op1_q) * PW'(digit)) << {cnt_q, 1'b0};

   always_comb begin
      state_d = state_q;
      op1_d   = op1_q;
      op2_d   = op2_q;
      prod_d  = prod_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         S_IDLE: begin
            if (accept) begin
               op1_d   = Input1;
               op2_d   = Input2;
               prod_d  = '0;
               cnt_d   = '0;
               state_d = S_CALC;
            end
         end
         S_CALC: begin
            prod_d = prod_q + partial;
            cnt_d  = cnt_q + 1'b1;
            if (cnt_q == LAST_CNT) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            if (OutReady) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q <= S_IDLE;
         op1_q   <= '0;
         op2_q   <= '0;
         prod_q  <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         op1_q   <= op1_d;
         op2_q   <= op2_d;
         prod_q  <= prod_d;
         cnt_q   <= cnt_d;
      end
   end

   assign InReady  = (state_q == S_IDLE);
   assign Busy     = (state_q == S_CALC);
   assign OutValid = (state_q == S_DONE);

`ifdef SEQ_MULT_CTRL_MAC_EN
   logic [PW-1:0] acc_q, acc_d;
   logic [PW-1:0] acc_sum;

   assign acc_sum = acc_q + prod_q;

   always_comb begin
      acc_d = acc_q;
      if ((state_q == S_IDLE) && AccClr) begin
         acc_d = '0;
      end else if (release_result) begin
         acc_d = acc_sum;
      end
   end

   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         acc_q <= '0;
      end else begin
         acc_q <= acc_d;
      end
   end

   // In IDLE the accumulator already includes the last product, so it is what remains visible.
   assign Output = (state_q == S_DONE) ? acc_sum : acc_q;
`else
   logic unused_release;
   assign unused_release = release_result;
   assign Output         = prod_q;
`endif

endmodule
